lru_age_tracker: RTL and testbench
==================================

Name: lru_age_tracker

Overview:
- Parametrised true-LRU replacement tracker for the set-associative cache. Holds one age per way per set, in flops.
- Generalises the 4-way age-compare scheme to WAYS ways and SETS sets.
- Adds registered request/response handshake and four operations: touch, allocate, invalidate and query.
- Sits beside the cache tag array; the cache controller issues one operation per accepted request.

Parameters:
- WAYS, 4, associativity; power of two, >= 2.
- SETS, 16, number of sets; power of two, >= 1.
- AGE_W, $clog2(WAYS), width of one age and of a way index (derived; do not override).
- SET_W, max(1,$clog2(SETS)), set index width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  tracker can accept a request.
- req_op  in  2  00 TOUCH, 01 ALLOC, 10 INVAL, 11 QUERY.
- req_set  in  SET_W  target set.
- req_way  in  AGE_W  way for TOUCH/INVAL; ignored for ALLOC/QUERY.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_way  out  AGE_W  TOUCH/INVAL: echo of req_way; ALLOC/QUERY: victim way.
- rsp_op  out  2  echo of req_op.

Behaviour:
- Age semantics: 0 = MRU, WAYS-1 = LRU. Ages within a set are always a permutation of 0..WAYS-1.
- Reset (async, while rst=1), for every set s and way i: age[s][i] = i. Also rsp_valid=0, rsp_way=0, rsp_op=0, req_ready=1.
- Accept when req_valid && req_ready. req_ready = !rsp_valid || rsp_ready (single-entry output register).
- Latency: request accepted at edge N. At that same edge the age update is written and rsp_* is registered, so rsp_valid=1 in cycle N+1.
- Back-to-back requests to the same set see the updated ages. No hazard or forwarding is needed.
- Victim v = the way whose age == WAYS-1. Exactly one such way exists.
- TOUCH way w, old age a: every way with age < a increments; w becomes 0; ways with age > a are unchanged.
- ALLOC: w = v, then apply TOUCH(v); rsp_way = v.
- INVAL way w, old age a: every way with age > a decrements; w becomes WAYS-1.
- QUERY: no state change; rsp_way = v.
- Per-way compare: each way produces inc (age < a) and dec (age > a). This is the generalisation of the 4-way comparator's decrement flag.
- TOUCH on an MRU way (a=0) or INVAL on an LRU way (a=WAYS-1): state unchanged, response still issued.
- Stall: while rsp_valid && !rsp_ready, rsp_* hold stable, req_ready=0 and no state update occurs.
- rsp_valid clears on rsp_ready when no new request is accepted in the same cycle. If rsp_ready && req_valid in the same cycle, the response register is reloaded (full throughput).
- Reset asserted mid-operation: pending response is dropped and all ages return to their reset permutation immediately.
- Only the addressed set is modified. Other sets hold their state.

Decomposition:
- Shared package lru_pkg holds the op encodings (OP_TOUCH=2'b00, OP_ALLOC=2'b01, OP_INVAL=2'b10, OP_QUERY=2'b11) and an age-width function.
- One sub-module, lru_age_update: purely combinational. Takes the WAYS ages of one set, the op and the way. Produces the new ages and the victim index using WAYS instances of the per-way inc/dec compare.
- The top level holds the SETS×WAYS age flops, the handshake and the response register.

Test Plan:
- Reset, then QUERY set 0 -> rsp_valid one cycle after accept, rsp_way=3 (WAYS=4), rsp_op=11; ages unchanged.
- TOUCH set 2 way 3, then QUERY set 2 -> ages {1,2,3,0}, rsp_way=2; set 0 still {0,1,2,3}.
- ALLOC set 5 four times back-to-back with rsp_ready=1 -> rsp_way sequence 3,2,1,0, one response per cycle, req_ready stays 1.
- INVAL set 1 way 0 from reset -> ages {3,0,1,2}; following ALLOC returns way 0.
- Hold rsp_ready=0 after one request, keep req_valid=1 -> req_ready=0, rsp_* stable, no age change; release -> queued request processed next edge.
- Assert rst mid-stall after several TOUCHes -> rsp_valid=0 immediately; after deassert, QUERY on any set returns WAYS-1. Repeat with WAYS=8, SETS=1 and check the permutation invariant after 1000 random ops.

Source files
------------

// File: rtl/lru_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lru_pkg
// Purpose : Shared definitions for the LRU age tracker: operation encodings
//           and the derived width helpers used by the tracker and its
//           per-set update block.
// Revision: 1.0 - initial release
// ============================================================================
package lru_pkg;

  // Operation encodings carried on req_op / rsp_op.
  typedef enum logic [1:0] {
    OP_TOUCH = 2'b00,
    OP_ALLOC = 2'b01,
    OP_INVAL = 2'b10,
    OP_QUERY = 2'b11
  } lru_op_e;

  // Width of one age value, which is also the width of a way index.
  function automatic int lru_age_width(input int ways);
    return (ways <= 1) ? 1 : $clog2(ways);
  endfunction

  // Width of a set index; never narrower than one bit.
  function automatic int lru_set_width(input int sets);
    return (sets <= 1) ? 1 : $clog2(sets);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lru_age_update.sv
`default_nettype none
// ============================================================================
// Module  : lru_age_update
// Purpose : Purely combinational next-age computation for one set.
//           Each way compares its age against the reference age (the age of
//           the addressed way, or of the victim for ALLOC) and produces an
//           inc flag (age < ref) and a dec flag (age > ref).
// Ports   : ages_in  - WAYS packed ages, way i at bits [i*AGE_W +: AGE_W]
//           op       - operation (TOUCH/ALLOC/INVAL/QUERY)
//           way      - addressed way (ignored for ALLOC/QUERY)
//           ages_out - updated ages, same packing as ages_in
//           victim   - way currently holding age WAYS-1 (before update)
// Revision: 1.0 - initial release
// ============================================================================
module lru_age_update
  import lru_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int AGE_W = lru_age_width(WAYS)
) (
  input  logic [WAYS*AGE_W-1:0] ages_in,
  input  logic [1:0]            op,
  input  logic [AGE_W-1:0]      way,
  output logic [WAYS*AGE_W-1:0] ages_out,
  output logic [AGE_W-1:0]      victim
);

  localparam logic [AGE_W-1:0] C_LRU_AGE = AGE_W'(WAYS - 1);

  logic [WAYS-1:0]  w_is_lru;
  logic [WAYS-1:0]  w_inc;
  logic [WAYS-1:0]  w_dec;
  logic [AGE_W-1:0] w_target;
  logic [AGE_W-1:0] w_ref_age;

  // Ages are a permutation, so exactly one way is LRU; OR-ing the indices of
  // the flagged ways yields that index without a priority chain.
  always_comb begin
    victim = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (w_is_lru[i]) begin
        victim = victim | AGE_W'(i);
      end
    end
  end

  // ALLOC behaves as a TOUCH of the victim way.
  assign w_target  = (op == OP_ALLOC) ? victim : way;
  assign w_ref_age = ages_in[w_target*AGE_W +: AGE_W];

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    logic [AGE_W-1:0] w_age;
    logic [AGE_W-1:0] w_new;
    logic             w_sel;

    assign w_age       = ages_in[i*AGE_W +: AGE_W];
    assign w_sel       = (w_target == AGE_W'(i));
    assign w_is_lru[i] = (w_age == C_LRU_AGE);
    assign w_inc[i]    = (w_age < w_ref_age);
    assign w_dec[i]    = (w_age > w_ref_age);

    always_comb begin
      w_new = w_age;
      case (op)
        OP_TOUCH, OP_ALLOC: begin
          if (w_sel) begin
            w_new = '0;
          end else if (w_inc[i]) begin
            w_new = w_age + AGE_W'(1);
          end
        end
        OP_INVAL: begin
          if (w_sel) begin
            w_new = C_LRU_AGE;
          end else if (w_dec[i]) begin
            w_new = w_age - AGE_W'(1);
          end
        end
        default: begin
          w_new = w_age;
        end
      endcase
    end

    assign ages_out[i*AGE_W +: AGE_W] = w_new;
  end

endmodule
`default_nettype wire

// File: rtl/lru_age_tracker.sv
`default_nettype none
// ============================================================================
// Module  : lru_age_tracker
// Purpose : True-LRU replacement tracker. Holds one age per way per set
//           (0 = MRU, WAYS-1 = LRU) and services TOUCH / ALLOC / INVAL /
//           QUERY requests through a valid/ready handshake with a
//           single-entry registered response.
// Ports   : clk, rst              - clock, async active-high reset
//           req_valid/req_ready   - request handshake
//           req_op/req_set/req_way- operation, target set, addressed way
//           rsp_valid/rsp_ready   - response handshake
//           rsp_way/rsp_op        - echoed way or victim, echoed op
// Revision: 1.0 - initial release
// ============================================================================
module lru_age_tracker
  import lru_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 16,
  parameter int AGE_W = lru_age_width(WAYS),
  parameter int SET_W = lru_set_width(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [SET_W-1:0] req_set,
  input  logic [AGE_W-1:0] req_way,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [AGE_W-1:0] rsp_way,
  output logic [1:0]       rsp_op
);

  localparam int ROW_W = WAYS * AGE_W;

  // Reset permutation: way i holds age i.
  function automatic logic [ROW_W-1:0] f_reset_row();
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < WAYS; i++) begin
      r[i*AGE_W +: AGE_W] = AGE_W'(i);
    end
    return r;
  endfunction

  localparam logic [ROW_W-1:0] C_RESET_ROW = f_reset_row();

  logic [ROW_W-1:0] age_q [SETS];
  logic [ROW_W-1:0] age_d [SETS];

  logic             rsp_valid_q, rsp_valid_d;
  logic [AGE_W-1:0] rsp_way_q,   rsp_way_d;
  logic [1:0]       rsp_op_q,    rsp_op_d;

  logic [SETS-1:0]  w_set_hit;
  logic [ROW_W-1:0] w_row;
  logic [ROW_W-1:0] w_row_new;
  logic [AGE_W-1:0] w_victim;
  logic             w_accept;

  // Single-entry output register: a new request may enter whenever the slot
  // is empty or is being drained in this same cycle.
  assign req_ready = !rsp_valid_q || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  // Set decode is written as a compare per set rather than an array index
  // so that a one-set configuration needs no zero-width index.
  always_comb begin
    w_set_hit = '0;
    w_row     = '0;
    for (int s = 0; s < SETS; s++) begin
      w_set_hit[s] = (SETS == 1) || (req_set == SET_W'(s));
      if (w_set_hit[s]) begin
        w_row = age_q[s];
      end
    end
  end

  lru_age_update #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_update (
    .ages_in  (w_row),
    .op       (req_op),
    .way      (req_way),
    .ages_out (w_row_new),
    .victim   (w_victim)
  );

  // Only the addressed set is written, and only on an accepted request.
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      age_d[s] = age_q[s];
      if (w_accept && w_set_hit[s]) begin
        age_d[s] = w_row_new;
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_way_d   = rsp_way_q;
    rsp_op_d    = rsp_op_q;
    if (w_accept) begin
      rsp_valid_d = 1'b1;
      rsp_op_d    = req_op;
      rsp_way_d   = ((req_op == OP_ALLOC) || (req_op == OP_QUERY)) ? w_victim : req_way;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        age_q[s] <= C_RESET_ROW;
      end
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
      rsp_op_q    <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) begin
        age_q[s] <= age_d[s];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_way_q   <= rsp_way_d;
      rsp_op_q    <= rsp_op_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_way   = rsp_way_q;
  assign rsp_op    = rsp_op_q;

endmodule
`default_nettype wire

// File: tb/tb_lru_age_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_lru_age_tracker
// Purpose : Self-checking bench for lru_age_tracker. Two instances: a 4-way
//           16-set tracker and an 8-way single-set tracker. The reference
//           model keeps, per set, the list of ways ordered from MRU to LRU;
//           a way's age is its position in that list.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lru_age_tracker;

  localparam int W1 = 4;
  localparam int S1 = 16;
  localparam int W2 = 8;
  localparam int S2 = 1;

  localparam logic [1:0] T_TOUCH = 2'b00;
  localparam logic [1:0] T_ALLOC = 2'b01;
  localparam logic [1:0] T_INVAL = 2'b10;
  localparam logic [1:0] T_QUERY = 2'b11;

  logic clk;
  logic rst;

  logic       a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [1:0] a_req_op, a_rsp_op;
  logic [3:0] a_req_set;
  logic [1:0] a_req_way, a_rsp_way;

  logic       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [1:0] b_req_op, b_rsp_op;
  logic [0:0] b_req_set;
  logic [2:0] b_req_way, b_rsp_way;

  int checks;
  int errors;

  lru_age_tracker #(.WAYS(W1), .SETS(S1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
    .req_set(a_req_set), .req_way(a_req_way),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_way(a_rsp_way), .rsp_op(a_rsp_op)
  );

  lru_age_tracker #(.WAYS(W2), .SETS(S2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_set(b_req_set), .req_way(b_req_way),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_way(b_rsp_way), .rsp_op(b_rsp_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: recency lists ----------------
  int ord [2][16][8];
  int nways [2] = '{W1, W2};
  int nsets [2] = '{S1, S2};

  function automatic void model_reset(input int m);
    for (int s = 0; s < nsets[m]; s++)
      for (int p = 0; p < nways[m]; p++)
        ord[m][s][p] = p;
  endfunction

  function automatic int model_pos(input int m, input int s, input int w);
    for (int p = 0; p < nways[m]; p++)
      if (ord[m][s][p] == w) return p;
    return -1;
  endfunction

  function automatic int model_victim(input int m, input int s);
    return ord[m][s][nways[m]-1];
  endfunction

  function automatic void model_to_front(input int m, input int s, input int w);
    int p;
    p = model_pos(m, s, w);
    for (int q = p; q > 0; q--) ord[m][s][q] = ord[m][s][q-1];
    ord[m][s][0] = w;
  endfunction

  function automatic void model_to_back(input int m, input int s, input int w);
    int p;
    p = model_pos(m, s, w);
    for (int q = p; q < nways[m]-1; q++) ord[m][s][q] = ord[m][s][q+1];
    ord[m][s][nways[m]-1] = w;
  endfunction

  // Applies one operation and returns the expected rsp_way.
  function automatic int model_apply(input int m, input logic [1:0] op, input int s, input int w);
    int v;
    case (op)
      T_TOUCH: begin model_to_front(m, s, w); return w; end
      T_ALLOC: begin v = model_victim(m, s); model_to_front(m, s, v); return v; end
      T_INVAL: begin model_to_back(m, s, w); return w; end
      default: return model_victim(m, s);
    endcase
  endfunction

  // Expected packed ages of a set: way w holds its list position.
  function automatic logic [63:0] model_row(input int m, input int s, input int aw);
    logic [63:0] r;
    r = '0;
    for (int p = 0; p < nways[m]; p++)
      r = r | (64'(p) << (ord[m][s][p] * aw));
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check_row_a(input int s, input string tag);
    logic [7:0] r;
    r = dut1.age_q[s];
    checks++;
    if (64'(r) !== model_row(0, s, 2)) begin
      errors++;
      $display("FAIL %s: set %0d ages=%h expected=%h", tag, s, r, model_row(0, s, 2));
    end
  endtask

  task automatic send_a(input logic [1:0] op, input int s, input int w, input string tag);
    int exp_way;
    int guard;
    a_req_valid = 1'b1; a_req_op = op; a_req_set = 4'(s); a_req_way = 2'(w);
    guard = 0;
    while (a_req_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for req_ready", tag);
      a_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    exp_way = model_apply(0, op, s, w);
    checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_way !== 2'(exp_way) || a_rsp_op !== op) begin
      errors++;
      $display("FAIL %s: rsp valid=%0b way=%0d op=%0d expected valid=1 way=%0d op=%0d",
               tag, a_rsp_valid, a_rsp_way, a_rsp_op, exp_way, op);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_rsp_way !== 2'd0 || a_rsp_op !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b ready=%0b way=%0d op=%0d expected 0 1 0 0",
               a_rsp_valid, a_req_ready, a_rsp_way, a_rsp_op);
    end
    for (int s = 0; s < S1; s++) check_row_a(s, "reset_ages");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_query();
    send_a(T_QUERY, 0, 0, "query_set0");
    check_row_a(0, "query_no_change");
    @(posedge clk); #1;
    checks++;
    if (a_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_drain: rsp_valid=%0b expected 0", a_rsp_valid);
    end
  endtask

  task automatic test_touch();
    send_a(T_TOUCH, 2, 3, "touch_s2w3");
    send_a(T_QUERY, 2, 0, "query_s2");
    check_row_a(2, "touch_ages");
    check_row_a(0, "other_set_kept");
  endtask

  task automatic test_back_to_back();
    int e;
    a_req_valid = 1'b1; a_req_op = T_ALLOC; a_req_set = 4'd5; a_req_way = 2'd0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready: beat %0d req_ready=%0b expected 1", k, a_req_ready);
      end
      @(posedge clk); #1;
      e = model_apply(0, T_ALLOC, 5, 0);
      checks++;
      if (a_rsp_valid !== 1'b1 || a_rsp_way !== 2'(e)) begin
        errors++;
        $display("FAIL b2b_alloc: beat %0d valid=%0b way=%0d expected valid=1 way=%0d",
                 k, a_rsp_valid, a_rsp_way, e);
      end
    end
    a_req_valid = 1'b0;
    check_row_a(5, "b2b_ages");
  endtask

  task automatic test_inval();
    send_a(T_INVAL, 1, 0, "inval_s1w0");
    check_row_a(1, "inval_ages");
    send_a(T_ALLOC, 1, 0, "alloc_after_inval");
    send_a(T_INVAL, 1, model_victim(0, 1), "inval_lru_noop");
    check_row_a(1, "inval_lru_ages");
  endtask

  task automatic test_stall();
    int e;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    send_a(T_TOUCH, 3, 2, "stall_first");
    a_req_valid = 1'b1; a_req_op = T_QUERY; a_req_set = 4'd3; a_req_way = 2'd1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (a_req_ready !== 1'b0 || a_rsp_valid !== 1'b1 || a_rsp_way !== 2'd2 || a_rsp_op !== T_TOUCH) begin
        errors++;
        $display("FAIL stall_hold: ready=%0b valid=%0b way=%0d op=%0d expected 0 1 2 0",
                 a_req_ready, a_rsp_valid, a_rsp_way, a_rsp_op);
      end
      check_row_a(3, "stall_ages");
    end
    a_rsp_ready = 1'b1;
    #1;
    checks++;
    if (a_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: req_ready=%0b expected 1", a_req_ready);
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    e = model_apply(0, T_QUERY, 3, 1);
    checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_way !== 2'(e) || a_rsp_op !== T_QUERY) begin
      errors++;
      $display("FAIL stall_release: valid=%0b way=%0d op=%0d expected 1 %0d 3",
               a_rsp_valid, a_rsp_way, a_rsp_op, e);
    end
  endtask

  task automatic test_reset_mid_stall();
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++)
      send_a(T_TOUCH, 6 + (k % 3), $urandom_range(0, 3), "pre_reset_touch");
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    send_a(T_TOUCH, 6, 1, "pre_reset_stall");
    a_req_valid = 1'b1; a_req_op = T_TOUCH; a_req_set = 4'd6; a_req_way = 2'd3;
    #2;
    rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    checks++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_stall: valid=%0b ready=%0b expected 0 1", a_rsp_valid, a_req_ready);
    end
    check_row_a(6, "reset_mid_ages6");
    check_row_a(7, "reset_mid_ages7");
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send_a(T_QUERY, 0, 0, "post_reset_q0");
    send_a(T_QUERY, 6, 0, "post_reset_q6");
    send_a(T_QUERY, 15, 0, "post_reset_q15");
  endtask

  task automatic test_random_a();
    logic [1:0] op;
    int s;
    int w;
    for (int k = 0; k < 200; k++) begin
      op = 2'($urandom_range(0, 3));
      s  = $urandom_range(0, S1 - 1);
      w  = $urandom_range(0, W1 - 1);
      send_a(op, s, w, "random_a");
    end
    for (int s2 = 0; s2 < S1; s2++) check_row_a(s2, "random_a_ages");
  endtask

  task automatic test_random_b();
    logic [1:0] op;
    int w;
    int e;
    logic [23:0] r;
    logic [7:0]  seen;
    @(posedge clk); #1;
    checks++;
    if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b_idle: valid=%0b ready=%0b expected 0 1", b_rsp_valid, b_req_ready);
    end
    b_req_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      op = 2'($urandom_range(0, 3));
      w  = $urandom_range(0, W2 - 1);
      b_req_op = op; b_req_set = 1'b0; b_req_way = 3'(w);
      @(posedge clk); #1;
      e = model_apply(1, op, 0, w);
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_way !== 3'(e) || b_rsp_op !== op) begin
        errors++;
        $display("FAIL random_b: op %0d valid=%0b way=%0d rspop=%0d expected 1 %0d %0d",
                 k, b_rsp_valid, b_rsp_way, b_rsp_op, e, op);
      end
    end
    b_req_valid = 1'b0;
    r = dut2.age_q[0];
    seen = '0;
    for (int i = 0; i < W2; i++) seen[r[i*3 +: 3]] = 1'b1;
    checks++;
    if (seen !== 8'hFF) begin
      errors++;
      $display("FAIL b_permutation: ages=%h coverage=%h expected ff", r, seen);
    end
    checks++;
    if (64'(r) !== model_row(1, 0, 3)) begin
      errors++;
      $display("FAIL b_ages: ages=%h expected=%h", r, model_row(1, 0, 3));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_op = 2'd0; a_req_set = 4'd0; a_req_way = 2'd0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_op = 2'd0; b_req_set = 1'b0; b_req_way = 3'd0; b_rsp_ready = 1'b1;
    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_query();
    test_touch();
    test_back_to_back();
    test_inval();
    test_stall();
    test_reset_mid_stall();
    test_random_a();
    test_random_b();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
